// File: rtl/rx_frame_len_counter_pkg.sv
// Shared receive-path constants and the frame length counter state encoding.
package rx_frame_len_counter_pkg;

    localparam int unsigned ETH_MIN_FRAME   = 64;
    localparam int unsigned ETH_MAX_FRAME   = 1518;
    localparam int unsigned ETH_JUMBO_FRAME = 9018;
    localparam int unsigned XGMII_LANES     = 8;

    typedef enum logic {
        StIdle  = 1'b0,
        StCount = 1'b1
    } rx_len_state_e;

endpackage

// File: rtl/rx_lane_popcount.sv
// Combinational count of asserted byte lanes.
module rx_lane_popcount #(
    parameter int unsigned LANES = 8,
    parameter int unsigned CW    = $clog2(LANES + 1)
) (
    input  logic [LANES-1:0] byte_en_i,
    output logic [CW-1:0]    count_o
);

    // Sum the lane bits; synthesis folds the chain into an adder tree.
    always_comb begin
        count_o = '0;
        for (int i = 0; i < LANES; i++) begin
            count_o = count_o + CW'(byte_en_i[i]);
        end
    end

endmodule

// File: rtl/rx_frame_len_counter.sv
// RX frame length counter: saturating per-frame byte/word accumulator with an
// end-of-frame latch for length and min/max checks.
module rx_frame_len_counter
    import rx_frame_len_counter_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned LANES     = XGMII_LANES,
    parameter int unsigned BYTE_MODE = 1,
    parameter int unsigned MIN_LEN   = ETH_MIN_FRAME,
    parameter int unsigned MAX_LEN   = ETH_MAX_FRAME
) (
    input  logic             rxclk,
    input  logic             reset,
    input  logic             receiving,
    input  logic [LANES-1:0] byte_en,
    output logic [WIDTH-1:0] frame_cnt,
    output logic             over_max,
    output logic             len_valid,
    output logic [WIDTH-1:0] frame_len,
    output logic             too_short,
    output logic             too_long,
    output logic             cnt_sat
);

    localparam int unsigned CW = $clog2(LANES + 1);

    localparam logic [WIDTH:0]   CntMax  = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH-1:0] MinLenW = WIDTH'(MIN_LEN);
    localparam logic [WIDTH-1:0] MaxLenW = WIDTH'(MAX_LEN);

    if ((MIN_LEN > MAX_LEN) || (64'(MAX_LEN) >= (64'(1) << WIDTH)) || (LANES < 1))
    begin : g_param_check
        $error("rx_frame_len_counter: need MIN_LEN <= MAX_LEN < 2**WIDTH and LANES >= 1");
    end

    rx_len_state_e    state_q;
    logic             receiving_d_q;
    logic [WIDTH-1:0] frame_cnt_q;
    logic             cnt_sat_int_q;
    logic             len_valid_q;
    logic [WIDTH-1:0] frame_len_q;
    logic             too_short_q;
    logic             too_long_q;
    logic             cnt_sat_q;

    logic [CW-1:0]    pop;
    logic [WIDTH:0]   inc;
    logic [WIDTH:0]   sum;
    logic             sat;
    logic [WIDTH-1:0] frame_cnt_d;
    logic             eof;

    rx_lane_popcount #(
        .LANES (LANES),
        .CW    (CW)
    ) u_popcount (
        .byte_en_i (byte_en),
        .count_o   (pop)
    );

    // Saturating next count and end-of-frame detection.
    always_comb begin
        inc         = (BYTE_MODE != 0) ? (WIDTH + 1)'(pop) : (WIDTH + 1)'(1);
        sum         = {1'b0, frame_cnt_q} + inc;
        sat         = (sum > CntMax);
        frame_cnt_d = sat ? CntMax[WIDTH-1:0] : sum[WIDTH-1:0];
        eof         = (state_q == StCount) && receiving_d_q && !receiving;
    end

    // FSM, accumulator and end-of-frame latch; reset discards any open frame.
    always_ff @(posedge rxclk) begin
        if (!reset) begin
            state_q       <= StIdle;
            receiving_d_q <= 1'b0;
            frame_cnt_q   <= '0;
            cnt_sat_int_q <= 1'b0;
            len_valid_q   <= 1'b0;
            frame_len_q   <= '0;
            too_short_q   <= 1'b0;
            too_long_q    <= 1'b0;
            cnt_sat_q     <= 1'b0;
        end else begin
            receiving_d_q <= receiving;
            unique case (state_q)
                StIdle:  if (receiving)  state_q <= StCount;
                StCount: if (!receiving) state_q <= StIdle;
                default: state_q <= StIdle;
            endcase

            if (receiving) begin
                frame_cnt_q   <= frame_cnt_d;
                cnt_sat_int_q <= cnt_sat_int_q | sat;
            end else begin
                frame_cnt_q   <= '0;
                cnt_sat_int_q <= 1'b0;
            end

            len_valid_q <= eof;
            if (eof) begin
                frame_len_q <= frame_cnt_q;
                too_short_q <= (frame_cnt_q < MinLenW);
                too_long_q  <= (frame_cnt_q > MaxLenW);
                cnt_sat_q   <= cnt_sat_int_q;
            end
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign over_max  = (frame_cnt_q > MaxLenW);
    assign len_valid = len_valid_q;
    assign frame_len = frame_len_q;
    assign too_short = too_short_q;
    assign too_long  = too_long_q;
    assign cnt_sat   = cnt_sat_q;

endmodule

// File: tb/tb_rx_frame_len_counter.sv
// Scoreboard bench for rx_frame_len_counter: byte mode, word mode and an
// 8-bit saturating instance all see the same stimulus.
module tb_rx_frame_len_counter;

    logic       rxclk = 1'b0;
    logic       reset;
    logic       receiving;
    logic [7:0] byte_en;

    logic [15:0] m_frame_cnt, m_frame_len;
    logic        m_over_max, m_len_valid, m_too_short, m_too_long, m_cnt_sat;
    logic [15:0] w_frame_cnt, w_frame_len;
    logic        w_over_max, w_len_valid, w_too_short, w_too_long, w_cnt_sat;
    logic [7:0]  s_frame_cnt, s_frame_len;
    logic        s_over_max, s_len_valid, s_too_short, s_too_long, s_cnt_sat;

    typedef struct packed {
        logic [15:0] len;
        logic        ts;
        logic        tl;
        logic        sat;
    } exp_t;

    exp_t q_main[$];
    exp_t q_word[$];
    exp_t q_small[$];

    int checks = 0;
    int passed = 0;
    int pulses_main = 0;
    int pulses_word = 0;
    int pulses_small = 0;

    always #5 rxclk = ~rxclk;

    rx_frame_len_counter u_main (
        .rxclk     (rxclk),
        .reset     (reset),
        .receiving (receiving),
        .byte_en   (byte_en),
        .frame_cnt (m_frame_cnt),
        .over_max  (m_over_max),
        .len_valid (m_len_valid),
        .frame_len (m_frame_len),
        .too_short (m_too_short),
        .too_long  (m_too_long),
        .cnt_sat   (m_cnt_sat)
    );

    rx_frame_len_counter #(
        .BYTE_MODE (0)
    ) u_word (
        .rxclk     (rxclk),
        .reset     (reset),
        .receiving (receiving),
        .byte_en   (byte_en),
        .frame_cnt (w_frame_cnt),
        .over_max  (w_over_max),
        .len_valid (w_len_valid),
        .frame_len (w_frame_len),
        .too_short (w_too_short),
        .too_long  (w_too_long),
        .cnt_sat   (w_cnt_sat)
    );

    rx_frame_len_counter #(
        .WIDTH   (8),
        .MIN_LEN (64),
        .MAX_LEN (200)
    ) u_small (
        .rxclk     (rxclk),
        .reset     (reset),
        .receiving (receiving),
        .byte_en   (byte_en),
        .frame_cnt (s_frame_cnt),
        .over_max  (s_over_max),
        .len_valid (s_len_valid),
        .frame_len (s_frame_len),
        .too_short (s_too_short),
        .too_long  (s_too_long),
        .cnt_sat   (s_cnt_sat)
    );

    // Expected latch contents for a frame of 'cnt' units on a given configuration.
    function automatic exp_t mk(longint cnt, int width, longint mn, longint mx);
        longint cap;
        longint len;
        exp_t   e;
        cap   = (longint'(1) << width) - 1;
        len   = (cnt > cap) ? cap : cnt;
        e.len = 16'(len);
        e.ts  = (len < mn);
        e.tl  = (len > mx);
        e.sat = (cnt > cap);
        return e;
    endfunction

    task automatic push_frame(input longint bytes, input longint words);
        q_main.push_back(mk(bytes, 16, 64, 1518));
        q_word.push_back(mk(words, 16, 64, 1518));
        q_small.push_back(mk(bytes, 8, 64, 200));
    endtask

    // One clock: inputs applied at negedge, outputs settled at the next negedge.
    task automatic cyc(input logic r, input logic [7:0] be);
        receiving = r;
        byte_en   = be;
        @(posedge rxclk);
        @(negedge rxclk);
    endtask

    // Scoreboard consumers: every len_valid pulse must match the oldest expectation.
    always @(negedge rxclk) begin
        exp_t e;
        if (m_len_valid === 1'b1) begin
            pulses_main++;
            checks++;
            if (q_main.size() == 0) begin
                $display("FAIL main_unexpected_pulse got len=%0d want no pulse", m_frame_len);
            end else begin
                e = q_main.pop_front();
                if ({m_frame_len, m_too_short, m_too_long, m_cnt_sat} !== e)
                    $display("FAIL main_frame got len=%0d ts=%b tl=%b sat=%b want len=%0d ts=%b tl=%b sat=%b",
                             m_frame_len, m_too_short, m_too_long, m_cnt_sat,
                             e.len, e.ts, e.tl, e.sat);
                else passed++;
            end
        end
    end

    always @(negedge rxclk) begin
        exp_t e;
        if (w_len_valid === 1'b1) begin
            pulses_word++;
            checks++;
            if (q_word.size() == 0) begin
                $display("FAIL word_unexpected_pulse got len=%0d want no pulse", w_frame_len);
            end else begin
                e = q_word.pop_front();
                if ({w_frame_len, w_too_short, w_too_long, w_cnt_sat} !== e)
                    $display("FAIL word_frame got len=%0d ts=%b tl=%b sat=%b want len=%0d ts=%b tl=%b sat=%b",
                             w_frame_len, w_too_short, w_too_long, w_cnt_sat,
                             e.len, e.ts, e.tl, e.sat);
                else passed++;
            end
        end
    end

    always @(negedge rxclk) begin
        exp_t e;
        if (s_len_valid === 1'b1) begin
            pulses_small++;
            checks++;
            if (q_small.size() == 0) begin
                $display("FAIL small_unexpected_pulse got len=%0d want no pulse", s_frame_len);
            end else begin
                e = q_small.pop_front();
                if ({8'h00, s_frame_len, s_too_short, s_too_long, s_cnt_sat} !== e)
                    $display("FAIL small_frame got len=%0d ts=%b tl=%b sat=%b want len=%0d ts=%b tl=%b sat=%b",
                             s_frame_len, s_too_short, s_too_long, s_cnt_sat,
                             e.len, e.ts, e.tl, e.sat);
                else passed++;
            end
        end
    end

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) cyc(1'b1, 8'hFF);
        checks++;
        if ({m_frame_cnt, m_over_max, m_len_valid, m_frame_len, m_too_short, m_too_long,
             m_cnt_sat, w_frame_cnt, s_frame_cnt} !== '0)
            $display("FAIL reset_outputs got cnt=%0d len=%0d lv=%b want all zero",
                     m_frame_cnt, m_frame_len, m_len_valid);
        else passed++;
        reset = 1'b1;
        cyc(1'b1, 8'hFF);
        checks++;
        if ({m_frame_cnt, w_frame_cnt} !== {16'd8, 16'd1})
            $display("FAIL reset_release_start got byte=%0d word=%0d want 8 1",
                     m_frame_cnt, w_frame_cnt);
        else passed++;
        cyc(1'b1, 8'hFF);
        push_frame(16, 2);
        cyc(1'b0, 8'h00);
        cyc(1'b0, 8'h00);
    endtask

    task automatic test_frame_64();
        int p0;
        p0 = pulses_main;
        for (int k = 1; k <= 8; k++) begin
            cyc(1'b1, 8'hFF);
            checks++;
            if (m_frame_cnt !== 16'(8 * k))
                $display("FAIL f64_step%0d got %0d want %0d", k, m_frame_cnt, 8 * k);
            else passed++;
        end
        push_frame(64, 8);
        cyc(1'b0, 8'h00);
        checks++;
        if (m_frame_cnt !== 16'd0) $display("FAIL f64_cnt_idle got %0d want 0", m_frame_cnt);
        else passed++;
        cyc(1'b0, 8'h00);
        checks++;
        if ({pulses_main - p0, m_len_valid, m_frame_len} !== {32'd1, 1'b0, 16'd64})
            $display("FAIL f64_single_pulse got pulses=%0d lv=%b len=%0d want 1 0 64",
                     pulses_main - p0, m_len_valid, m_frame_len);
        else passed++;
    endtask

    task automatic test_partial_tail();
        repeat (7) cyc(1'b1, 8'hFF);
        cyc(1'b1, 8'h07);
        checks++;
        if (m_frame_cnt !== 16'd59) $display("FAIL tail_cnt got %0d want 59", m_frame_cnt);
        else passed++;
        push_frame(59, 8);
        cyc(1'b0, 8'h00);
        cyc(1'b0, 8'h00);
        checks++;
        if ({m_frame_len, m_too_short, w_frame_len, w_too_short} !== {16'd59, 1'b1, 16'd8, 1'b1})
            $display("FAIL tail_held got byte=%0d/%b word=%0d/%b want 59/1 8/1",
                     m_frame_len, m_too_short, w_frame_len, w_too_short);
        else passed++;
    endtask

    task automatic test_oversize();
        for (int k = 1; k <= 190; k++) begin
            cyc(1'b1, 8'hFF);
            if (k == 189) begin
                checks++;
                if ({m_frame_cnt, m_over_max} !== {16'd1512, 1'b0})
                    $display("FAIL over_max_below got cnt=%0d om=%b want 1512 0",
                             m_frame_cnt, m_over_max);
                else passed++;
            end
            if (k == 190) begin
                checks++;
                if ({m_frame_cnt, m_over_max} !== {16'd1520, 1'b1})
                    $display("FAIL over_max_above got cnt=%0d om=%b want 1520 1",
                             m_frame_cnt, m_over_max);
                else passed++;
            end
        end
        push_frame(1520, 190);
        cyc(1'b0, 8'h00);
        checks++;
        if (m_over_max !== 1'b0) $display("FAIL over_max_idle got %b want 0", m_over_max);
        else passed++;
        cyc(1'b0, 8'h00);
    endtask

    task automatic test_saturation();
        for (int k = 1; k <= 40; k++) begin
            cyc(1'b1, 8'hFF);
            if (k == 31 || k == 32 || k == 40) begin
                checks++;
                if (s_frame_cnt !== ((k == 31) ? 8'd248 : 8'd255))
                    $display("FAIL sat_step%0d got %0d want %0d", k, s_frame_cnt,
                             (k == 31) ? 248 : 255);
                else passed++;
            end
        end
        push_frame(320, 40);
        cyc(1'b0, 8'h00);
        cyc(1'b0, 8'h00);
        checks++;
        if ({s_frame_len, s_cnt_sat, s_too_long, m_cnt_sat} !== {8'd255, 1'b1, 1'b1, 1'b0})
            $display("FAIL sat_held got len=%0d sat=%b tl=%b main_sat=%b want 255 1 1 0",
                     s_frame_len, s_cnt_sat, s_too_long, m_cnt_sat);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int p0;
        p0 = pulses_main;
        repeat (3) cyc(1'b1, 8'hFF);
        push_frame(24, 3);
        cyc(1'b0, 8'h00);
        cyc(1'b1, 8'h81);
        checks++;
        if ({m_frame_cnt, w_frame_cnt} !== {16'd2, 16'd1})
            $display("FAIL b2b_restart got byte=%0d word=%0d want 2 1", m_frame_cnt, w_frame_cnt);
        else passed++;
        cyc(1'b1, 8'h00);
        checks++;
        if (m_frame_cnt !== 16'd2) $display("FAIL b2b_zero_en got %0d want 2", m_frame_cnt);
        else passed++;
        cyc(1'b1, 8'h81);
        push_frame(4, 3);
        cyc(1'b0, 8'h00);
        cyc(1'b0, 8'h00);
        checks++;
        if (pulses_main - p0 !== 2)
            $display("FAIL b2b_pulses got %0d want 2", pulses_main - p0);
        else passed++;
    endtask

    task automatic test_reset_mid_frame();
        int p0;
        p0 = pulses_main + pulses_word + pulses_small;
        repeat (5) cyc(1'b1, 8'hFF);
        reset = 1'b0;
        cyc(1'b1, 8'hFF);
        reset = 1'b1;
        cyc(1'b0, 8'h00);
        cyc(1'b0, 8'h00);
        cyc(1'b0, 8'h00);
        checks++;
        if ({pulses_main + pulses_word + pulses_small - p0, m_frame_len, m_frame_cnt, m_len_valid}
            !== {32'd0, 16'd0, 16'd0, 1'b0})
            $display("FAIL abort_no_pulse got pulses=%0d len=%0d cnt=%0d want 0 0 0",
                     pulses_main + pulses_word + pulses_small - p0, m_frame_len, m_frame_cnt);
        else passed++;
    endtask

    initial begin
        reset     = 1'b0;
        receiving = 1'b0;
        byte_en   = 8'h00;
        @(negedge rxclk);
        test_reset();
        test_frame_64();
        test_partial_tail();
        test_oversize();
        test_saturation();
        test_back_to_back();
        test_reset_mid_frame();
        checks++;
        if (q_main.size() + q_word.size() + q_small.size() != 0)
            $display("FAIL missing_pulses got %0d outstanding want 0",
                     q_main.size() + q_word.size() + q_small.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
